gfx_blit_dma: RTL and testbench

- Parametrised 2D blitter; successor to the single-mode GFX DMA.
- Copies or fills a WxH rectangle from the data-RAM bank into VRAM, with independent source and destination row strides, a data mask and an optional colour-key skip.
- Sits between the CPU bus, the DRAM bus drivers and the VRAM address mux.
- Destination writes are issued only in cycles where the VGA engine reports the VRAM bus free.

---
 rtl/gfx_blit_dma.sv | 188 ++++++++++++++++++
 tb/tb_gfx_blit_dma.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_blit_dma.sv
// 2D blitter: copies (or fills) a WxH rectangle from DRAM into VRAM, with masking and colour-key skip.
// Latency: copy SrcLatency+1 cycles/pixel, fill 1 cycle/pixel; stalls in WAIT_BUS while the VGA engine owns VRAM.
module gfx_blit_dma #(
    parameter int         SrcAddrWidth  = 15,
    parameter int         DstAddrWidth  = 16,
    parameter int         SrcLatency    = 2,
    parameter logic [7:0] DefaultStride = 8'd160
) (
    input  logic                    i_clk,
    input  logic                    i_rst_b,
    input  logic                    i_ce_b,
    input  logic                    i_we_b,
    input  logic [3:0]              i_reg_addr,
    input  logic [7:0]              i_reg_data,
    output logic [SrcAddrWidth-1:0] o_src_addr,
    output logic                    o_src_re_b,
    input  logic [7:0]              i_src_data,
    output logic [DstAddrWidth-1:0] o_dst_addr,
    output logic [7:0]              o_dst_data,
    output logic                    o_dst_we_b,
    input  logic                    i_free_vbus,
    output logic                    o_active,
    output logic                    o_addr_sel,
    output logic                    o_done
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_BUS, S_WRITE, S_DONE} state_t;

    state_t state_q, state_d;

    logic [SrcAddrWidth-1:0] src_q, src_row_q, src_ptr_q;
    logic [DstAddrWidth-1:0] dst_q, dst_row_q, dst_ptr_q;
    logic [7:0] width_q, height_q, mask_q, dstride_q, sstride_q, value_q;
    logic [7:0] col_q, row_q, pix_q, pix_src;
    logic [2:0] lat_q;
    logic mode_q, keyen_q, go_q, active;
    logic wr_en, ctrl_wr, abort_wr, start_wr;
    logic last_read, col_wrap, last_pixel, key_hit;
    logic do_latch, do_capture, do_advance;
    state_t wr_or_wait, next_pix;

    assign active   = (state_q != S_IDLE);
    assign wr_en    = !i_ce_b && !i_we_b;
    assign ctrl_wr  = wr_en && (i_reg_addr == 4'd7);
    assign abort_wr = ctrl_wr && i_reg_data[7];
    assign start_wr = ctrl_wr && !i_reg_data[7] && !active;

    // CPU register file; only ABORT gets through while a blit is running.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            src_q     <= '0;
            dst_q     <= '0;
            width_q   <= '0;
            height_q  <= '0;
            mask_q    <= 8'hFF;
            mode_q    <= 1'b0;
            keyen_q   <= 1'b0;
            dstride_q <= DefaultStride;
            sstride_q <= DefaultStride;
            value_q   <= '0;
            go_q      <= 1'b0;
        end else begin
            go_q <= start_wr;
            if (wr_en && !active) begin
                case (i_reg_addr)
                    4'd0: src_q[7:0] <= i_reg_data;
                    4'd1: src_q[SrcAddrWidth-1:8] <= i_reg_data[SrcAddrWidth-9:0];
                    4'd2: dst_q[7:0] <= i_reg_data;
                    4'd3: dst_q[DstAddrWidth-1:8] <= i_reg_data[DstAddrWidth-9:0];
                    4'd4: width_q <= i_reg_data;
                    4'd5: height_q <= i_reg_data;
                    4'd6: mask_q <= i_reg_data;
                    4'd7: if (!i_reg_data[7]) begin
                        mode_q  <= i_reg_data[0];
                        keyen_q <= i_reg_data[1];
                    end
                    4'd8: dstride_q <= i_reg_data;
                    4'd9: sstride_q <= i_reg_data;
                    4'd10: value_q <= i_reg_data;
                    default: ;
                endcase
            end
        end
    end

    assign pix_src    = i_src_data & mask_q;
    assign key_hit    = keyen_q && !mode_q && (pix_src == (value_q & mask_q));
    assign last_read  = (lat_q == 3'(SrcLatency - 1));
    assign col_wrap   = ((col_q + 8'd1) == width_q);
    assign last_pixel = col_wrap && ((row_q + 8'd1) == height_q);
    // WAIT_BUS costs no cycle when the bus is already free.
    assign wr_or_wait = i_free_vbus ? S_WRITE : S_WAIT_BUS;
    assign next_pix   = last_pixel ? S_DONE : (mode_q ? wr_or_wait : S_READ);

    always_comb begin
        state_d    = state_q;
        do_latch   = 1'b0;
        do_capture = 1'b0;
        do_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go_q) begin
                    if (width_q == 8'd0 || height_q == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        do_latch = 1'b1;
                        state_d  = mode_q ? wr_or_wait : S_READ;
                    end
                end
            end
            S_READ: begin
                if (last_read) begin
                    do_capture = 1'b1;
                    if (key_hit) begin
                        do_advance = 1'b1;
                        state_d    = next_pix;
                    end else begin
                        state_d = wr_or_wait;
                    end
                end
            end
            S_WAIT_BUS: if (i_free_vbus) state_d = S_WRITE;
            S_WRITE: begin
                do_advance = 1'b1;
                state_d    = next_pix;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_wr && (state_q == S_READ || state_q == S_WAIT_BUS || state_q == S_WRITE))
            state_d = S_DONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            col_q     <= '0;
            row_q     <= '0;
            src_row_q <= '0;
            src_ptr_q <= '0;
            dst_row_q <= '0;
            dst_ptr_q <= '0;
            pix_q     <= '0;
            lat_q     <= '0;
        end else begin
            if (state_q == S_READ && !last_read) lat_q <= lat_q + 3'd1;
            else                                 lat_q <= '0;
            if (do_latch) begin
                col_q     <= '0;
                row_q     <= '0;
                src_row_q <= src_q;
                src_ptr_q <= src_q;
                dst_row_q <= dst_q;
                dst_ptr_q <= dst_q;
                if (mode_q) pix_q <= value_q & mask_q;
            end
            if (do_capture) pix_q <= pix_src;
            if (do_advance) begin
                if (col_wrap) begin
                    col_q     <= '0;
                    row_q     <= row_q + 8'd1;
                    src_row_q <= src_row_q + SrcAddrWidth'(sstride_q);
                    src_ptr_q <= src_row_q + SrcAddrWidth'(sstride_q);
                    dst_row_q <= dst_row_q + DstAddrWidth'(dstride_q);
                    dst_ptr_q <= dst_row_q + DstAddrWidth'(dstride_q);
                end else begin
                    col_q     <= col_q + 8'd1;
                    src_ptr_q <= src_ptr_q + SrcAddrWidth'(1);
                    dst_ptr_q <= dst_ptr_q + DstAddrWidth'(1);
                end
            end
        end
    end

    assign o_src_addr = src_ptr_q;
    assign o_src_re_b = (state_q != S_READ);
    assign o_dst_addr = dst_ptr_q;
    assign o_dst_data = pix_q;
    assign o_dst_we_b = (state_q != S_WRITE);
    assign o_active   = active;
    assign o_addr_sel = active;
    assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_gfx_blit_dma.sv
// Directed bench for gfx_blit_dma: scoreboard of expected VRAM writes plus cycle-count checks.
module tb_gfx_blit_dma;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, ce_b, we_b, free_vbus;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data, src_data, dst_data;
    logic [14:0] src_addr;
    logic [15:0] dst_addr;
    logic        src_re_b, dst_we_b, active, addr_sel, done;

    gfx_blit_dma dut (
        .i_clk(clk), .i_rst_b(rst_b), .i_ce_b(ce_b), .i_we_b(we_b),
        .i_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_src_addr(src_addr), .o_src_re_b(src_re_b), .i_src_data(src_data),
        .o_dst_addr(dst_addr), .o_dst_data(dst_data), .o_dst_we_b(dst_we_b),
        .i_free_vbus(free_vbus), .o_active(active), .o_addr_sel(addr_sel), .o_done(done)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    logic [7:0] mem [0:255];
    int vectors = 0, fails = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: data valid on the second cycle of a read (latency 2).
    always @(posedge clk) src_data <= !src_re_b ? mem[src_addr[7:0]] : 8'hEE;

    always @(negedge clk) begin
        if (rst_b) begin
            if (!src_re_b) rd_cnt++;
            if (done) done_cnt++;
            check("addr_sel_eq_active", addr_sel, active);
            if (!dst_we_b) begin
                wr_cnt++;
                check("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", dst_addr, mon_e.addr);
                    check("wr_data", dst_data, mon_e.data);
                end
            end
        end
    end

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ce_b = 1'b0; we_b = 1'b0; reg_addr = a; reg_data = d;
        @(posedge clk);
        #1;
        ce_b = 1'b1; we_b = 1'b1;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [7:0] w, input logic [7:0] h);
        wr_reg(4'd0, s[7:0]); wr_reg(4'd1, s[15:8]);
        wr_reg(4'd2, d[7:0]); wr_reg(4'd3, d[15:8]);
        wr_reg(4'd4, w);      wr_reg(4'd5, h);
    endtask

    task automatic push_rect(input logic [15:0] s, input logic [15:0] d, input int w, input int h,
                             input logic [7:0] sstr, input logic [7:0] dstr, input logic [7:0] mask,
                             input logic [7:0] val, input bit fill, input bit keyen);
        wr_t t;
        int sa;
        logic [7:0] px;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                sa = (int'(s) + r * int'(sstr) + c) & 32'h7FFF;
                px = (fill ? val : mem[sa[7:0]]) & mask;
                if (!(keyen && !fill && px == (val & mask))) begin
                    t.addr = 16'((int'(d) + r * int'(dstr) + c) & 32'hFFFF);
                    t.data = px;
                    exp_q.push_back(t);
                end
            end
        end
    endtask

    task automatic wait_done(input int t0, output int k);
        k = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                k = cyc - t0 + 1;
                break;
            end
        end
    endtask

    int t0, k, w0, r0, d0, stall_k;
    logic [15:0] stall_addr;
    bit found;

    initial begin
        rst_b = 1'b0; ce_b = 1'b1; we_b = 1'b1; reg_addr = '0; reg_data = '0; free_vbus = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        repeat (3) @(negedge clk);
        check("rst_src_re_b", src_re_b, 1);
        check("rst_dst_we_b", dst_we_b, 1);
        check("rst_active", active, 0);
        check("rst_addr_sel", addr_sel, 0);
        check("rst_done", done, 0);
        check("rst_src_addr", src_addr, 0);
        check("rst_dst_addr", dst_addr, 0);
        check("rst_dst_data", dst_data, 0);
        rst_b = 1'b1;

        // Copy 5x5; DSTRIDE and MASK left at their reset values (160, FF).
        setup(16'h0000, 16'h1010, 8'd5, 8'd5);
        wr_reg(4'd9, 8'd5);
        push_rect(16'h0000, 16'h1010, 5, 5, 8'd5, 8'd160, 8'hFF, 8'h00, 1'b0, 1'b0);
        w0 = wr_cnt;
        wr_reg(4'd7, 8'h00);
        t0 = cyc;
        while (cyc - t0 + 1 < 11) @(negedge clk);
        wr_reg(4'd4, 8'd1);
        wait_done(t0, k);
        check("copy_done_cycle", k, 77);
        check("copy_writes", wr_cnt - w0, 25);
        check("copy_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("active_dropped", active, 0);

        // Fill with mask.
        setup(16'h0000, 16'h2000, 8'd2, 8'd1);
        wr_reg(4'd10, 8'hA5); wr_reg(4'd6, 8'h0F);
        push_rect(16'h0000, 16'h2000, 2, 1, 8'd5, 8'd160, 8'h0F, 8'hA5, 1'b1, 1'b0);
        wr_reg(4'd7, 8'h01);
        t0 = cyc;
        wait_done(t0, k);
        check("fill_done_cycle", k, 4);
        check("fill_queue_empty", exp_q.size(), 0);

        // Colour-key copy.
        mem[64] = 8'h00; mem[65] = 8'h11; mem[66] = 8'h00; mem[67] = 8'h22;
        setup(16'h0040, 16'h2100, 8'd4, 8'd1);
        wr_reg(4'd10, 8'h00); wr_reg(4'd6, 8'hFF);
        push_rect(16'h0040, 16'h2100, 4, 1, 8'd5, 8'd160, 8'hFF, 8'h00, 1'b0, 1'b1);
        check("key_expected_count", exp_q.size(), 2);
        w0 = wr_cnt;
        wr_reg(4'd7, 8'h02);
        t0 = cyc;
        wait_done(t0, k);
        check("key_done_cycle", k, 12);
        check("key_writes", wr_cnt - w0, 2);
        check("key_queue_empty", exp_q.size(), 0);

        // Bus stall of 10 cycles during a fill.
        setup(16'h0000, 16'h3000, 8'd8, 8'd1);
        wr_reg(4'd10, 8'h3C);
        push_rect(16'h0000, 16'h3000, 8, 1, 8'd5, 8'd160, 8'hFF, 8'h3C, 1'b1, 1'b0);
        w0 = wr_cnt;
        wr_reg(4'd7, 8'h01);
        t0 = cyc;
        stall_k = -1;
        stall_addr = '0;
        for (int i = 0; i < 200 && stall_k < 0; i++) begin
            @(negedge clk);
            k = cyc - t0 + 1;
            if (k >= 4 && k <= 13) begin
                check("stall_no_write", dst_we_b, 1);
                if (k == 4) begin
                    stall_addr = dst_addr;
                    check("stall_addr", dst_addr, 16'h3002);
                end else begin
                    check("stall_addr_hold", dst_addr, stall_addr);
                end
            end
            if (k == 3) free_vbus = 1'b0;
            if (k == 13) free_vbus = 1'b1;
            if (done === 1'b1) stall_k = k;
        end
        free_vbus = 1'b1;
        check("stall_done_cycle", stall_k, 20);
        check("stall_writes", wr_cnt - w0, 8);
        check("stall_queue_empty", exp_q.size(), 0);

        // ABORT during the third pixel of a 4x4 copy.
        setup(16'h0000, 16'h4000, 8'd4, 8'd4);
        wr_reg(4'd9, 8'd4);
        push_rect(16'h0000, 16'h4000, 2, 1, 8'd4, 8'd160, 8'hFF, 8'h00, 1'b0, 1'b0);
        w0 = wr_cnt;
        wr_reg(4'd7, 8'h00);
        t0 = cyc;
        while (cyc - t0 + 1 < 7) @(negedge clk);
        wr_reg(4'd7, 8'h80);
        t0 = cyc;
        wait_done(t0, k);
        check("abort_done_within_2", 32'(k >= 1 && k <= 2), 1);
        check("abort_at_most_3_writes", 32'((wr_cnt - w0) <= 3), 1);
        check("abort_queue_empty", exp_q.size(), 0);
        wr_reg(4'd4, 8'd1); wr_reg(4'd5, 8'd1);
        push_rect(16'h0000, 16'h4000, 1, 1, 8'd4, 8'd160, 8'hFF, 8'h00, 1'b0, 1'b0);
        w0 = wr_cnt;
        wr_reg(4'd7, 8'h00);
        t0 = cyc;
        wait_done(t0, k);
        check("post_abort_done_cycle", k, 5);
        check("post_abort_writes", wr_cnt - w0, 1);

        // Destination wrap-around.
        setup(16'h0000, 16'hFFFF, 8'd2, 8'd1);
        wr_reg(4'd10, 8'h77);
        push_rect(16'h0000, 16'hFFFF, 2, 1, 8'd4, 8'd160, 8'hFF, 8'h77, 1'b1, 1'b0);
        wr_reg(4'd7, 8'h01);
        t0 = cyc;
        wait_done(t0, k);
        check("wrap_done_cycle", k, 4);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Zero width.
        wr_reg(4'd4, 8'd0);
        w0 = wr_cnt; r0 = rd_cnt;
        wr_reg(4'd7, 8'h00);
        t0 = cyc;
        wait_done(t0, k);
        check("w0_done_cycle", k, 2);
        check("w0_writes", wr_cnt - w0, 0);
        check("w0_reads", rd_cnt - r0, 0);

        // ABORT while idle, and start+abort in one write.
        wr_reg(4'd4, 8'd2); wr_reg(4'd5, 8'd1);
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        wr_reg(4'd7, 8'h80);
        repeat (6) @(negedge clk);
        check("idle_abort_no_done", done_cnt - d0, 0);
        wr_reg(4'd7, 8'h81);
        repeat (6) @(negedge clk);
        check("start_abort_no_active", active, 0);
        check("start_abort_no_done", done_cnt - d0, 0);
        check("start_abort_no_access", (wr_cnt - w0) + (rd_cnt - r0), 0);

        // Asynchronous reset in the middle of a copy.
        setup(16'h0000, 16'h5000, 8'd4, 8'd4);
        push_rect(16'h0000, 16'h5000, 4, 4, 8'd4, 8'd160, 8'hFF, 8'h00, 1'b0, 1'b0);
        wr_reg(4'd7, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dst_we_b === 1'b0) found = 1'b1;
        end
        check("reset_found_write", found, 1);
        #1 rst_b = 1'b0;
        #1;
        check("reset_async_active", active, 0);
        check("reset_async_we_b", dst_we_b, 1);
        check("reset_async_re_b", src_re_b, 1);
        check("reset_async_dst_addr", dst_addr, 0);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (40) @(negedge clk);
        check("reset_no_later_writes", wr_cnt - w0, 0);
        check("reset_stays_idle", active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
